regfile_operand_fetch: RTL
==========================

Name: regfile_operand_fetch

Overview:
- Client-side initiator for the 2-read/1-write register file port (read_en, rs1_addr, rs2_addr, rs1_data, rs2_data, write_en, write_addr, write_data).
- Accepts operand-fetch requests from decode and issues regfile reads. Captures the returned data and hands operands to execute over a valid/ready handshake.
- Also registers writeback traffic onto the write port and forwards in-flight writes into pending operands, so execute never sees stale data.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- TAG_W, 5, passthrough tag width (destination register of the instruction)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  decode request valid
- req_ready  out  1  block can accept a request
- req_rs1  in  ADDR_W  source register 1
- req_rs2  in  ADDR_W  source register 2
- req_tag  in  TAG_W  tag carried to the output
- op_valid  out  1  operands valid
- op_ready  in  1  execute accepts operands
- op_rs1_data  out  DATA_W  operand 1
- op_rs2_data  out  DATA_W  operand 2
- op_tag  out  TAG_W  tag of the request
- wb_valid  in  1  writeback request (always accepted)
- wb_addr  in  ADDR_W  writeback register
- wb_data  in  DATA_W  writeback data
- read_en  out  1  regfile read enable
- rs1_addr  out  ADDR_W  regfile read address 1
- rs2_addr  out  ADDR_W  regfile read address 2
- rs1_data  in  DATA_W  regfile read data 1
- rs2_data  in  DATA_W  regfile read data 2
- write_en  out  1  regfile write enable
- write_addr  out  ADDR_W  regfile write address
- write_data  out  DATA_W  regfile write data

Behaviour:
- Regfile contract:
  - A write commits at the rising edge where write_en=1.
  - rs1_data/rs2_data are valid in the cycle after read_en is high.
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - read_en, write_en, op_valid go to 0. All address, data and tag outputs go to 0.
  - req_ready=0 while rst is high.
- FSM states: IDLE, RD, CAP, OUT.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch rs1, rs2 and tag, then go to RD.
  - RD: read_en=1; rs1_addr/rs2_addr hold the latched addresses. Go to CAP.
  - CAP: read_en=0. Load the operand registers from rs1_data/rs2_data, with forwarding applied. Go to OUT.
  - OUT: op_valid=1. Operands and tag stay stable until op_valid&&op_ready, then go to IDLE.
  - req_ready=0 in RD, CAP and OUT.
- Latency: request accepted in cycle N → read_en high in N+1 → capture at end of N+2 → op_valid in N+3. Minimum spacing between accepted requests is 4 cycles.
- Write path: wb_valid/wb_addr/wb_data are registered to write_en/write_addr/write_data with 1-cycle latency, in every state including IDLE. No backpressure.
- Forwarding window: from the accept cycle through the op handshake cycle.
  - Any wb_valid sampled in the window whose wb_addr matches latched rs1 (rs2) overrides operand 1 (operand 2) with wb_data.
  - The latest wb in the window wins over regfile data and over earlier forwards.
  - A wb in the CAP cycle wins over rs*_data.
  - A wb in OUT updates the held operand at the next edge. op_valid stays high.
  - If rs1==rs2, both operands are updated.
- A wb sampled before the accept cycle is not forwarded; it is already committed before the read edge.
- Reset mid-operation: the request is abandoned and op_valid=0 after the reset edge. A write registered but not yet committed is dropped (write_en=0).

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired zero.
  - An operand whose latched address is 0 is forced to 0 regardless of rs*_data or forwarding.
  - wb_valid with wb_addr=0 produces write_en=0.
- Undefined: register 0 is an ordinary register, for reads, writes and forwarding.

Test Plan:
- Reset then idle: rst high 2 cycles → all outputs 0; after release, req_ready=1, op_valid=0.
- Basic fetch: preload r21=0x0000ABCD, r17=0x0000ABC0 via wb; req rs1=21, rs2=17, tag=3 → read_en one cycle, op_valid 3 cycles after accept with op_rs1_data=0xABCD, op_rs2_data=0xABC0, op_tag=3.
- Backpressure: op_ready=0 for 5 cycles in OUT → op_valid and data held stable; req_ready=0; handshake on cycle 6 → IDLE, req_ready=1.
- Forwarding race: r20=0xA0CD; wb r20=0x1111 in the accept cycle, then wb r20=0x2222 in the CAP cycle; req rs1=rs2=20 → both operands =0x2222. A further wb r20=0x3333 during OUT updates both operands to 0x3333.
- Reset mid-op: assert rst in CAP with a wb pending → op_valid=0 and write_en=0 after the edge; the next request returns the pre-reset regfile contents.
- With REGFILE_ZERO_REG_EN: wb r0=0xFFFF → write_en stays 0; req rs1=0, rs2=19 (0x0BCD) → op_rs1_data=0, op_rs2_data=0x0BCD.

Source files
------------

// File: rtl/regfile_operand_fetch.sv
// regfile_operand_fetch: operand fetch from a 2R/1W register file with writeback forwarding.
// Optional REGFILE_ZERO_REG_EN makes register 0 read as zero and ignore writes.
`default_nettype none

module regfile_operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_rs1_data,
    output logic [DATA_W-1:0] op_rs2_data,
    output logic [TAG_W-1:0]  op_tag,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              read_en,
    output logic [ADDR_W-1:0] rs1_addr,
    output logic [ADDR_W-1:0] rs2_addr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic              fwd1_q, fwd1_d, fwd2_q, fwd2_d;
    logic              wen_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic [ADDR_W-1:0] cmp1, cmp2;
    logic              hit1, hit2, wb_ok;

    assign accept = (state_q == S_IDLE) && req_valid && !rst;

    // During the accept cycle the addresses are not latched yet, so compare against the request.
    assign cmp1  = (state_q == S_IDLE) ? req_rs1 : rs1_q;
    assign cmp2  = (state_q == S_IDLE) ? req_rs2 : rs2_q;
    assign hit1  = wb_valid && (wb_addr == cmp1) && !(ZERO_EN && (cmp1 == '0));
    assign hit2  = wb_valid && (wb_addr == cmp2) && !(ZERO_EN && (cmp2 == '0));
    assign wb_ok = wb_valid && !(ZERO_EN && (wb_addr == '0));

    always_comb begin
        state_d = state_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        tag_d   = tag_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        fwd1_d  = fwd1_q;
        fwd2_d  = fwd2_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    tag_d   = req_tag;
                    fwd1_d  = hit1;
                    fwd2_d  = hit2;
                    op1_d   = hit1 ? wb_data : op1_q;
                    op2_d   = hit2 ? wb_data : op2_q;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (hit1) begin
                    fwd1_d = 1'b1;
                    op1_d  = wb_data;
                end
                if (hit2) begin
                    fwd2_d = 1'b1;
                    op2_d  = wb_data;
                end
                state_d = S_CAP;
            end
            S_CAP: begin
                // Priority: same-cycle writeback, then earlier forward, then regfile data.
                op1_d = hit1 ? wb_data : (fwd1_q ? op1_q : rs1_data);
                op2_d = hit2 ? wb_data : (fwd2_q ? op2_q : rs2_data);
                if (ZERO_EN && (rs1_q == '0)) op1_d = '0;
                if (ZERO_EN && (rs2_q == '0)) op2_d = '0;
                state_d = S_OUT;
            end
            default: begin
                if (hit1) op1_d = wb_data;
                if (hit2) op2_d = wb_data;
                if (op_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            tag_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            fwd1_q  <= 1'b0;
            fwd2_q  <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            tag_q   <= tag_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            fwd1_q  <= fwd1_d;
            fwd2_q  <= fwd2_d;
            wen_q   <= wb_ok;
            waddr_q <= wb_addr;
            wdata_q <= wb_data;
        end
    end

    assign req_ready   = (state_q == S_IDLE) && !rst;
    assign read_en     = (state_q == S_RD);
    assign rs1_addr    = rs1_q;
    assign rs2_addr    = rs2_q;
    assign op_valid    = (state_q == S_OUT);
    assign op_rs1_data = op1_q;
    assign op_rs2_data = op2_q;
    assign op_tag      = tag_q;
    assign write_en    = wen_q;
    assign write_addr  = waddr_q;
    assign write_data  = wdata_q;

endmodule

`default_nettype wire
